// File: rtl/victim_evict_unit.sv
// Victim-cache fill sender: writes each evicted L1 line into the victim cache,
// drains dirty lines to memory as a beat burst, and exposes the held line to lookups.
module victim_evict_unit #(
  parameter int TAG_WIDTH  = 26,
  parameter int LINE_WIDTH = 512,
  parameter int BEAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  evict_valid,
  output logic                  evict_ready,
  input  logic [TAG_WIDTH-1:0]  evict_tag,
  input  logic [LINE_WIDTH-1:0] evict_data,
  input  logic                  evict_dirty,
  output logic                  vc_we,
  output logic [TAG_WIDTH-1:0]  vc_w_tag,
  output logic [LINE_WIDTH-1:0] vc_data,
  input  logic [TAG_WIDTH-1:0]  lookup_tag,
  output logic                  buf_hit,
  output logic [LINE_WIDTH-1:0] buf_data,
  output logic                  wr_req,
  output logic [31:0]           wr_addr,
  input  logic                  wr_rdy,
  output logic [BEAT_WIDTH-1:0] wr_data,
  output logic                  wr_data_valid,
  input  logic                  wr_data_ready,
  output logic                  wr_last,
  input  logic                  wr_done,
  output logic                  busy
);

  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT    = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] PENULT_BEAT  = CNT_W'(BEATS - 2);

  typedef enum logic [2:0] {IDLE, VC_WR, MEM_AW, MEM_W, MEM_B} state_t;

  state_t                               state;
  logic [CNT_W-1:0]                     cnt;
  logic [TAG_WIDTH-1:0]                 held_tag;
  logic [BEATS-1:0][BEAT_WIDTH-1:0]     held_data;
  logic                                 held_dirty;

  // The held line is the only copy while in flight, so it is visible in every busy state.
  assign evict_ready = (state == IDLE) && rstn;
  assign busy        = (state != IDLE);
  assign buf_hit     = (state != IDLE) && (lookup_tag == held_tag);
  assign buf_data    = held_data;
  assign vc_w_tag    = held_tag;
  assign vc_data     = held_data;
  assign wr_addr     = 32'({held_tag, {OFF_W{1'b0}}});
  assign wr_data     = held_data[cnt];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      cnt           <= '0;
      held_tag      <= '0;
      held_data     <= '0;
      held_dirty    <= 1'b0;
      vc_we         <= 1'b0;
      wr_req        <= 1'b0;
      wr_data_valid <= 1'b0;
      wr_last       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (evict_valid) begin
            held_tag   <= evict_tag;
            held_data  <= evict_data;
            held_dirty <= evict_dirty;
            vc_we      <= 1'b1;
            state      <= VC_WR;
          end
        end
        VC_WR: begin
          vc_we <= 1'b0;
          if (held_dirty) begin
            wr_req <= 1'b1;
            state  <= MEM_AW;
          end else begin
            state  <= IDLE;
          end
        end
        MEM_AW: begin
          if (wr_rdy) begin
            wr_req        <= 1'b0;
            cnt           <= '0;
            wr_data_valid <= 1'b1;
            wr_last       <= (BEATS == 1);
            state         <= MEM_W;
          end
        end
        MEM_W: begin
          // wr_last is registered one handshake ahead so it rises with the final beat.
          if (wr_data_ready) begin
            if (cnt == LAST_BEAT) begin
              wr_data_valid <= 1'b0;
              wr_last       <= 1'b0;
              state         <= MEM_B;
            end else begin
              cnt     <= cnt + 1'b1;
              wr_last <= (cnt == PENULT_BEAT);
            end
          end
        end
        MEM_B: begin
          if (wr_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_victim_evict_unit.sv
// Directed bench for victim_evict_unit: a table of single evictions plus
// hand-written sequences for snoop, back-to-back acceptance and mid-burst reset.
module tb_victim_evict_unit;

  logic         clk = 1'b0;
  logic         rstn;
  logic         evict_valid;
  logic         evict_ready;
  logic [25:0]  evict_tag;
  logic [511:0] evict_data;
  logic         evict_dirty;
  logic         vc_we;
  logic [25:0]  vc_w_tag;
  logic [511:0] vc_data;
  logic [25:0]  lookup_tag;
  logic         buf_hit;
  logic [511:0] buf_data;
  logic         wr_req;
  logic [31:0]  wr_addr;
  logic         wr_rdy;
  logic [31:0]  wr_data;
  logic         wr_data_valid;
  logic         wr_data_ready;
  logic         wr_last;
  logic         wr_done;
  logic         busy;

  victim_evict_unit dut (
    .clk(clk), .rstn(rstn),
    .evict_valid(evict_valid), .evict_ready(evict_ready), .evict_tag(evict_tag),
    .evict_data(evict_data), .evict_dirty(evict_dirty),
    .vc_we(vc_we), .vc_w_tag(vc_w_tag), .vc_data(vc_data),
    .lookup_tag(lookup_tag), .buf_hit(buf_hit), .buf_data(buf_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_rdy(wr_rdy),
    .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
    .wr_last(wr_last), .wr_done(wr_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [25:0] tag;
    logic        dirty;
    logic [31:0] base;
    int          rdy_delay;
    int          bp_mode;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[4];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [511:0] make_line(input logic [31:0] base);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  function automatic logic bp_ready(input int mode, input int cyc);
    case (mode)
      1:       return (cyc % 2) == 0;
      2:       return (cyc % 3) == 2;
      default: return 1'b1;
    endcase
  endfunction

  // Called at a negedge with the unit in IDLE; returns at the negedge of VC_WR.
  task automatic accept(input logic [25:0] tag, input logic [511:0] data, input logic dirty);
    evict_valid = 1'b1;
    evict_tag   = tag;
    evict_data  = data;
    evict_dirty = dirty;
    tick();
    evict_valid = 1'b0;
  endtask

  // From the first MEM_W negedge, stream all beats and check each one.
  task automatic drain(input string nm, input logic [31:0] base, input int mode);
    int beat = 0;
    int cyc  = 0;
    while (beat < 16 && cyc < 200) begin
      chk({nm, " valid"}, wr_data_valid, 1'b1);
      chk({nm, " beat"},  wr_data, base + 32'(beat));
      chk({nm, " last"},  wr_last, (beat == 15));
      wr_data_ready = bp_ready(mode, cyc);
      tick();
      if (wr_data_ready) beat++;
      cyc++;
    end
    chk({nm, " burst finished within budget"}, (cyc < 200), 1'b1);
    wr_data_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk({nm, " no beat after last"}, wr_data_valid, 1'b0);
      chk({nm, " last low after burst"}, wr_last, 1'b0);
      chk({nm, " busy in MEM_B"}, busy, 1'b1);
      tick();
    end
    wr_data_ready = 1'b0;
  endtask

  task automatic finish_b(input string nm);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    chk({nm, " ready after done"}, evict_ready, 1'b1);
    chk({nm, " idle after done"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [25:0]  t;
    logic [511:0] la, lb;

    vecs[0] = '{tag: 26'h0ABCDE,  dirty: 1'b0, base: 32'hA5A5_0000, rdy_delay: 0, bp_mode: 0, exp_addr: 32'h02AF_3780};
    vecs[1] = '{tag: 26'h0000041, dirty: 1'b1, base: 32'h1000_0000, rdy_delay: 3, bp_mode: 0, exp_addr: 32'h0000_1040};
    vecs[2] = '{tag: 26'h3FFFFFF, dirty: 1'b1, base: 32'hDEAD_0000, rdy_delay: 0, bp_mode: 1, exp_addr: 32'hFFFF_FFC0};
    vecs[3] = '{tag: 26'h2000001, dirty: 1'b1, base: 32'h0000_0100, rdy_delay: 1, bp_mode: 2, exp_addr: 32'h8000_0040};

    rstn = 1'b0; evict_valid = 1'b0; evict_tag = '0; evict_data = '0; evict_dirty = 1'b0;
    lookup_tag = '0; wr_rdy = 1'b0; wr_data_ready = 1'b0; wr_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset vc_we", vc_we, 1'b0);
    chk("reset wr_req", wr_req, 1'b0);
    chk("reset wr_data_valid", wr_data_valid, 1'b0);
    chk("reset wr_last", wr_last, 1'b0);
    chk("reset buf_hit", buf_hit, 1'b0);
    chk("reset busy", busy, 1'b0);
    rstn = 1'b1;
    tick();
    chk("post-reset evict_ready", evict_ready, 1'b1);

    for (int v = 0; v < 4; v++) begin
      la = make_line(vecs[v].base);
      chk("pre ready", evict_ready, 1'b1);
      accept(vecs[v].tag, la, vecs[v].dirty);
      chk("vc_we strobe", vc_we, 1'b1);
      chk("vc_w_tag", vc_w_tag, vecs[v].tag);
      chk("vc_data", vc_data, la);
      chk("ready low in VC_WR", evict_ready, 1'b0);
      tick();
      chk("vc_we one cycle", vc_we, 1'b0);
      if (!vecs[v].dirty) begin
        chk("clean ready back", evict_ready, 1'b1);
        chk("clean no wr_req", wr_req, 1'b0);
        tick();
        chk("clean still no wr_req", wr_req, 1'b0);
      end else begin
        for (int d = 0; d < vecs[v].rdy_delay; d++) begin
          chk("wr_req held", wr_req, 1'b1);
          chk("wr_addr stable", wr_addr, vecs[v].exp_addr);
          tick();
        end
        chk("wr_req", wr_req, 1'b1);
        chk("wr_addr", wr_addr, vecs[v].exp_addr);
        wr_rdy = 1'b1;
        tick();
        wr_rdy = 1'b0;
        chk("wr_req dropped", wr_req, 1'b0);
        drain("vec", vecs[v].base, vecs[v].bp_mode);
        finish_b("vec");
      end
    end

    // Snoop on the held line, and wr_done outside MEM_B must not end the transfer.
    t  = 26'h1234567;
    la = make_line(32'h7700_0000);
    lookup_tag = t;
    accept(t, la, 1'b1);
    chk("snoop hit in VC_WR", buf_hit, 1'b1);
    wr_rdy = 1'b1;
    tick();
    tick();
    wr_rdy = 1'b0;
    chk("snoop hit in MEM_W", buf_hit, 1'b1);
    chk("snoop buf_data", buf_data, la);
    lookup_tag = t ^ 26'h1;
    #1;
    chk("snoop miss on T^1", buf_hit, 1'b0);
    lookup_tag = t;
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    chk("wr_done ignored in MEM_W busy", busy, 1'b1);
    chk("wr_done ignored in MEM_W valid", wr_data_valid, 1'b1);
    drain("snoop", 32'h7700_0000, 0);
    chk("snoop hit in MEM_B", buf_hit, 1'b1);
    finish_b("snoop");
    chk("snoop no hit in IDLE", buf_hit, 1'b0);

    // Second line held on the request port throughout the first writeback.
    la = make_line(32'h5000_0000);
    lb = make_line(32'h6000_0000);
    lookup_tag = 26'h0000ACE;
    accept(26'h0000ACE, la, 1'b1);
    evict_valid = 1'b1; evict_tag = 26'h0000B0B; evict_data = lb; evict_dirty = 1'b0;
    tick();
    chk("b2b ready low in MEM_AW", evict_ready, 1'b0);
    chk("b2b wr_addr", wr_addr, 32'h0002_B380);
    wr_rdy = 1'b1;
    tick();
    wr_rdy = 1'b0;
    chk("b2b held data unchanged", buf_data, la);
    chk("b2b first tag still hit", buf_hit, 1'b1);
    drain("b2b", 32'h5000_0000, 0);
    chk("b2b ready low in MEM_B", evict_ready, 1'b0);
    chk("b2b no vc_we in MEM_B", vc_we, 1'b0);
    finish_b("b2b");
    tick();
    evict_valid = 1'b0;
    chk("b2b second vc_we", vc_we, 1'b1);
    chk("b2b second vc_w_tag", vc_w_tag, 26'h0000B0B);
    chk("b2b second vc_data", vc_data, lb);
    tick();
    chk("b2b second clean done", busy, 1'b0);

    // Reset while the burst sits at beat 7.
    la = make_line(32'h3300_0000);
    lookup_tag = 26'h0000777;
    accept(26'h0000777, la, 1'b1);
    wr_rdy = 1'b1;
    tick();
    tick();
    wr_rdy = 1'b0;
    wr_data_ready = 1'b1;
    repeat (7) tick();
    wr_data_ready = 1'b0;
    chk("rst at beat 7 data", wr_data, 32'h3300_0007);
    rstn = 1'b0;
    #1;
    chk("rst vc_we", vc_we, 1'b0);
    chk("rst wr_req", wr_req, 1'b0);
    chk("rst wr_data_valid", wr_data_valid, 1'b0);
    chk("rst wr_last", wr_last, 1'b0);
    chk("rst buf_hit", buf_hit, 1'b0);
    chk("rst evict_ready", evict_ready, 1'b0);
    chk("rst busy", busy, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst release ready", evict_ready, 1'b1);
    wr_data_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no beats after reset", wr_data_valid, 1'b0);
      chk("idle after reset", busy, 1'b0);
    end
    wr_data_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
